// File: rtl/instruction_queue_pkg.sv
// rtl/instruction_queue_pkg.sv - shared widths, NOP encoding and entry layout for the instruction queue
package instruction_queue_pkg;

    localparam int INS_WIDTH    = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int IQ_DEPTH_LOG = 3;

    // addi x0, x0, 0: harmless op handed to the decoder when the queue is empty
    localparam logic [INS_WIDTH-1:0] NOP_INS = 32'h0000_0013;

    typedef struct packed {
        logic [INS_WIDTH-1:0]  code;
        logic [ADDR_WIDTH-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - fetch-to-decode instruction FIFO with flush and optional empty-queue bypass
//
// Buffers {code, pc} pairs from fetch and presents the head entry to decode.
// Optional feature macro: IQ_BYPASS_EN (0-cycle fetch->decode path when empty).
//
// Ports:
//   clk_in, rstn_in        clock, asynchronous active-low reset
//   rdy_in                 global ready; 0 freezes push/pop (flush still honoured)
//   flush_in               drop all entries at the next edge
//   push_valid_in/code/pc  fetch side; held by fetch while full_out=1
//   full_out               no free entry (pointer state only)
//   pop_valid_out/code/pc  head entry; NOP/0 when empty
//   pop_ready_in           decode consumes the head this cycle
//   count_out              entries held, 0..DEPTH
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH_LOG = IQ_DEPTH_LOG
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  push_valid_in,
    input  logic [INS_WIDTH-1:0]  push_code_in,
    input  logic [ADDR_WIDTH-1:0] push_pc_in,
    output logic                  full_out,
    output logic                  pop_valid_out,
    output logic [INS_WIDTH-1:0]  pop_code_out,
    output logic [ADDR_WIDTH-1:0] pop_pc_out,
    input  logic                  pop_ready_in,
    output logic [DEPTH_LOG:0]    count_out
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DEPTH_LOG:0] head;
    logic [DEPTH_LOG:0] tail;
    iq_entry_t          slots [DEPTH];

    logic empty;
    logic push_acc;
    logic pop_acc;
    logic push_wr;
    logic head_adv;

    assign empty    = (head == tail);
    assign full_out = (head[DEPTH_LOG-1:0] == tail[DEPTH_LOG-1:0]) &&
                      (head[DEPTH_LOG] != tail[DEPTH_LOG]);
    assign count_out = tail - head;

    assign push_acc = rdy_in & push_valid_in & ~full_out & ~flush_in;
    assign pop_acc  = rdy_in & pop_valid_out & pop_ready_in & ~flush_in;

    // A pop while empty can only be a bypassed entry: it is consumed straight
    // from the push port, so neither pointer moves and nothing is written.
    assign push_wr  = push_acc & ~(empty & pop_acc);
    assign head_adv = pop_acc & ~empty;

    always_comb begin
        pop_valid_out = ~empty;
        pop_code_out  = slots[head[DEPTH_LOG-1:0]].code;
        pop_pc_out    = slots[head[DEPTH_LOG-1:0]].pc;
        if (empty) begin
            pop_code_out = NOP_INS;
            pop_pc_out   = '0;
`ifdef IQ_BYPASS_EN
            if (push_valid_in && rdy_in && !flush_in) begin
                pop_valid_out = 1'b1;
                pop_code_out  = push_code_in;
                pop_pc_out    = push_pc_in;
            end
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            head <= '0;
            tail <= '0;
        end else if (flush_in) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_wr)  tail <= tail + 1'b1;
            if (head_adv) head <= head + 1'b1;
        end
    end

    // Slot contents need no reset: they are only visible when the pointers say so.
    always_ff @(posedge clk_in) begin
        if (push_wr) begin
            slots[tail[DEPTH_LOG-1:0]] <= '{code: push_code_in, pc: push_pc_in};
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed self-checking bench for instruction_queue
module tb_instruction_queue;

    logic        clk_in = 1'b0;
    logic        rstn_in;
    logic        rdy_in;
    logic        flush_in;
    logic        push_valid_in;
    logic [31:0] push_code_in;
    logic [31:0] push_pc_in;
    logic        full_out;
    logic        pop_valid_out;
    logic [31:0] pop_code_out;
    logic [31:0] pop_pc_out;
    logic        pop_ready_in;
    logic [3:0]  count_out;

    int checks   = 0;
    int failures = 0;

    instruction_queue dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .push_valid_in (push_valid_in),
        .push_code_in  (push_code_in),
        .push_pc_in    (push_pc_in),
        .full_out      (full_out),
        .pop_valid_out (pop_valid_out),
        .pop_code_out  (pop_code_out),
        .pop_pc_out    (pop_pc_out),
        .pop_ready_in  (pop_ready_in),
        .count_out     (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_one(input logic [31:0] code, input logic [31:0] pc);
        push_valid_in = 1'b1;
        push_code_in  = code;
        push_pc_in    = pc;
        step();
        push_valid_in = 1'b0;
    endtask

    initial begin
        rstn_in       = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        push_code_in  = '0;
        push_pc_in    = '0;
        pop_ready_in  = 1'b0;

        // reset held for three cycles
        repeat (3) step();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_valid", 32'(pop_valid_out), 32'd0);
        check("rst_code",  pop_code_out, 32'h0000_0013);
        check("rst_pc",    pop_pc_out, 32'd0);
        check("rst_full",  32'(full_out), 32'd0);
        rstn_in = 1'b1;

        // empty queue must not show a pending push before its edge
        push_valid_in = 1'b1;
        push_code_in  = 32'h0000_1000;
        push_pc_in    = 32'h0;
        #1;
        check("no_bypass_valid", 32'(pop_valid_out), 32'd0);
        check("no_bypass_code",  pop_code_out, 32'h0000_0013);

        // fill eight entries with decode stalled
        for (int i = 0; i < 8; i++) begin
            push_one(32'h0000_1000 + 32'(i), 32'(i * 4));
            check($sformatf("fill_count_%0d", i), 32'(count_out), 32'(i + 1));
            check($sformatf("fill_full_%0d", i), 32'(full_out), (i == 7) ? 32'd1 : 32'd0);
        end
        check("fill_head_pc", pop_pc_out, 32'h0);

        // ninth push is dropped
        push_one(32'h0000_1008, 32'h20);
        check("overflow_count", 32'(count_out), 32'd8);
        check("overflow_full",  32'(full_out), 32'd1);

        // drain in order; the first drain cycle also offers a push that full must reject
        pop_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_valid_in = (i == 0);
            push_code_in  = 32'h0000_dead;
            push_pc_in    = 32'h20;
            check($sformatf("drain_valid_%0d", i), 32'(pop_valid_out), 32'd1);
            check($sformatf("drain_pc_%0d", i), pop_pc_out, 32'(i * 4));
            check($sformatf("drain_code_%0d", i), pop_code_out, 32'h0000_1000 + 32'(i));
            step();
            if (i == 0) check("full_push_rejected", 32'(count_out), 32'd7);
        end
        push_valid_in = 1'b0;
        check("drain_empty_valid", 32'(pop_valid_out), 32'd0);
        check("drain_empty_code",  pop_code_out, 32'h0000_0013);
        check("drain_empty_pc",    pop_pc_out, 32'd0);
        check("drain_empty_count", 32'(count_out), 32'd0);

        // steady push/pop with one-cycle skew across pointer wrap
        for (int k = 0; k <= 20; k++) begin
            push_valid_in = (k < 20);
            push_code_in  = 32'h0000_2000 + 32'(k);
            push_pc_in    = 32'h100 + 32'(k * 4);
            pop_ready_in  = (k > 0);
            if (k > 0) begin
                check($sformatf("wrap_pc_%0d", k), pop_pc_out, 32'h100 + 32'((k - 1) * 4));
                check($sformatf("wrap_code_%0d", k), pop_code_out, 32'h0000_2000 + 32'(k - 1));
                check($sformatf("wrap_count_%0d", k), 32'(count_out), 32'd1);
            end
            step();
        end
        push_valid_in = 1'b0;
        pop_ready_in  = 1'b0;
        check("wrap_end_count", 32'(count_out), 32'd0);

        // flush wins even with rdy low and a push offered
        for (int i = 0; i < 5; i++) push_one(32'h0000_3000 + 32'(i), 32'h300 + 32'(i * 4));
        check("preflush_count", 32'(count_out), 32'd5);
        rdy_in        = 1'b0;
        flush_in      = 1'b1;
        push_valid_in = 1'b1;
        push_pc_in    = 32'h3ff0;
        step();
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        check("flush_count", 32'(count_out), 32'd0);
        check("flush_valid", 32'(pop_valid_out), 32'd0);
        check("flush_full",  32'(full_out), 32'd0);
        rdy_in = 1'b1;

        // stall: rdy low freezes push and pop
        push_one(32'h0000_4000, 32'h400);
        push_one(32'h0000_4001, 32'h404);
        rdy_in        = 1'b0;
        push_valid_in = 1'b1;
        push_pc_in    = 32'h408;
        pop_ready_in  = 1'b1;
        repeat (3) step();
        check("stall_count", 32'(count_out), 32'd2);
        check("stall_pc",    pop_pc_out, 32'h400);
        rdy_in        = 1'b1;
        push_valid_in = 1'b0;
        step();
        check("unstall_count", 32'(count_out), 32'd1);
        check("unstall_pc",    pop_pc_out, 32'h404);
        pop_ready_in = 1'b0;

        // asynchronous reset mid-operation, between clock edges
        #2;
        rstn_in = 1'b0;
        #1;
        check("async_rst_count", 32'(count_out), 32'd0);
        check("async_rst_valid", 32'(pop_valid_out), 32'd0);
        check("async_rst_code",  pop_code_out, 32'h0000_0013);
        check("async_rst_pc",    pop_pc_out, 32'd0);
        step();
        rstn_in = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
